// File: rtl/input_vector_loader.sv
// input_vector_loader: assembles a framed word stream into one wide vector for the output-bit modules.
// Optional even-parity check on each accepted word when LOADER_PARITY_EN is defined.
module input_vector_loader #(
    parameter int VEC_W  = 1894,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
`ifdef LOADER_PARITY_EN
    input  logic              in_parity,
`endif
    output logic              in_ready,
    output logic [VEC_W-1:0]  i_vec,
    output logic              vec_valid,
    input  logic              vec_ack,
    output logic              frame_err,
    output logic [15:0]       frame_cnt
);
    localparam int NWORDS = (VEC_W + WORD_W - 1) / WORD_W;
    localparam int CW = NWORDS > 1 ? $clog2(NWORDS) : 1;
    localparam logic [CW-1:0] LASTW = CW'(NWORDS - 1);

    typedef enum logic [1:0] {LOAD, PRESENT, DRAIN} state_t;

    state_t        r_state, w_state;
    logic [CW-1:0] r_wcnt, w_wcnt;
    logic          r_ready, r_valid, r_err;
    logic [15:0]   r_cnt;
    logic          w_acc, w_wr, w_perr, w_err;

    assign w_acc = in_valid & r_ready;
    assign w_wr  = w_acc & (r_state == LOAD);
`ifdef LOADER_PARITY_EN
    assign w_perr = ^in_data ^ in_parity;
`else
    assign w_perr = 1'b0;
`endif

    // Any frame-ending event in LOAD resets the word count; only a clean, full-length frame presents.
    always_comb begin
        w_state = r_state;
        w_wcnt  = r_wcnt;
        w_err   = 1'b0;
        case (r_state)
            LOAD: if (w_acc) begin
                w_wcnt = r_wcnt + 1'b1;
                if (w_perr || in_last || r_wcnt == LASTW) begin
                    w_wcnt  = '0;
                    w_err   = w_perr || !in_last || r_wcnt != LASTW;
                    w_state = in_last ? (w_err ? LOAD : PRESENT) : DRAIN;
                end
            end
            PRESENT: w_state = vec_ack ? LOAD : PRESENT;
            DRAIN:   w_state = (w_acc && in_last) ? LOAD : DRAIN;
            default: w_state = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
            r_wcnt  <= '0;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state;
            r_wcnt  <= w_wcnt;
            r_ready <= w_state != PRESENT;
            r_valid <= w_state == PRESENT;
            r_err   <= w_err;
            r_cnt   <= r_cnt + 16'(r_state == PRESENT && vec_ack);
        end
    end

    // One register per word slice; the final slice is truncated to the vector width.
    for (genvar k = 0; k < NWORDS; k++) begin : g_word
        localparam int LO = k * WORD_W;
        localparam int LW = (VEC_W - LO < WORD_W) ? VEC_W - LO : WORD_W;
        logic [LW-1:0] r_slice;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_slice <= '0;
            else if (w_wr && r_wcnt == CW'(k))
                r_slice <= in_data[LW-1:0];
        end
        assign i_vec[LO +: LW] = r_slice;
    end

    assign in_ready  = r_ready;
    assign vec_valid = r_valid;
    assign frame_err = r_err;
    assign frame_cnt = r_cnt;
endmodule

// File: tb/tb_input_vector_loader.sv
// tb_input_vector_loader: directed self-checking bench for input_vector_loader.
// Exercises the parity path when LOADER_PARITY_EN is defined.
module tb_input_vector_loader;
    localparam int VEC_W  = 1894;
    localparam int WORD_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [WORD_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              vec_ack = 1'b0;
    logic              in_ready, vec_valid, frame_err;
    logic [VEC_W-1:0]  i_vec;
    logic [15:0]       frame_cnt;
`ifdef LOADER_PARITY_EN
    logic              in_parity = 1'b0;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    input_vector_loader #(.VEC_W(VEC_W), .WORD_W(WORD_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_last(in_last),
`ifdef LOADER_PARITY_EN
        .in_parity(in_parity),
`endif
        .in_ready(in_ready),
        .i_vec(i_vec),
        .vec_valid(vec_valid),
        .vec_ack(vec_ack),
        .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int first, input int last_idx, input int last_at, input int bad);
        for (int k = first; k <= last_idx; k++) begin
            in_valid = 1'b1;
            in_data  = 32'(k) * 32'h0101_0101;
            in_last  = (k == last_at);
`ifdef LOADER_PARITY_EN
            in_parity = ^in_data ^ (k == bad);
`else
            if (k == bad) in_data = in_data;
`endif
            step;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_valid"}, 64'(vec_valid), 64'd1);
        chk({tag, "_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_err"}, 64'(frame_err), 64'd0);
        chk({tag, "_w0"}, 64'(i_vec[31:0]), 64'h0);
        chk({tag, "_w1"}, 64'(i_vec[63:32]), 64'h0101_0101);
        chk({tag, "_w30"}, 64'(i_vec[991:960]), 64'h1E1E_1E1E);
        chk({tag, "_w59"}, 64'(i_vec[1893:1888]), 64'h3B);
    endtask

    task automatic do_ack;
        vec_ack = 1'b1;
        step;
        vec_ack = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_valid", 64'(vec_valid), 64'd0);
        chk("rst_err", 64'(frame_err), 64'd0);
        chk("rst_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_vec", i_vec[63:0], 64'd0);
        step;
        rst_n = 1'b1;
        chk("ready_pre", 64'(in_ready), 64'd0);
        step;
        chk("ready_rise", 64'(in_ready), 64'd1);

        send(0, 59, 59, -1);
        check_frame("f1");
        chk("f1_cnt", 64'(frame_cnt), 64'd0);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 20; i++) begin
            step;
            chk("hold_ready", 64'(in_ready), 64'd0);
            chk("hold_valid", 64'(vec_valid), 64'd1);
            chk("hold_vec", i_vec[63:0], 64'h0101_0101_0000_0000);
        end
        chk("hold_cnt", 64'(frame_cnt), 64'd0);
        do_ack;
        in_valid = 1'b0;
        chk("ack_ready", 64'(in_ready), 64'd1);
        chk("ack_valid", 64'(vec_valid), 64'd0);
        chk("ack_cnt", 64'(frame_cnt), 64'd1);

        send(0, 10, 10, -1);
        chk("short_err", 64'(frame_err), 64'd1);
        chk("short_valid", 64'(vec_valid), 64'd0);
        vec_ack = 1'b1;
        step;
        vec_ack = 1'b0;
        chk("short_pulse", 64'(frame_err), 64'd0);
        chk("stray_ack_cnt", 64'(frame_cnt), 64'd1);
        send(0, 59, 59, -1);
        check_frame("f2");
        chk("f2_cnt", 64'(frame_cnt), 64'd1);
        do_ack;
        chk("f2_ack_cnt", 64'(frame_cnt), 64'd2);

        send(0, 59, -1, -1);
        chk("long_err", 64'(frame_err), 64'd1);
        chk("long_valid", 64'(vec_valid), 64'd0);
        chk("long_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        step;
        chk("drain_pulse", 64'(frame_err), 64'd0);
        step;
        in_last = 1'b1;
        step;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("drain_valid", 64'(vec_valid), 64'd0);
        chk("drain_ready", 64'(in_ready), 64'd1);
        chk("drain_discard", 64'(i_vec[31:0]), 64'h0);
        chk("drain_cnt", 64'(frame_cnt), 64'd2);
        send(0, 59, 59, -1);
        check_frame("f3");
        do_ack;
        chk("f3_cnt", 64'(frame_cnt), 64'd3);

        send(0, 29, -1, -1);
        in_valid = 1'b1;
        in_data  = 32'h1E1E_1E1E;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vec", i_vec[63:0], 64'd0);
        chk("mid_rst_top", 64'(i_vec[1893:1888]), 64'd0);
        chk("mid_rst_cnt", 64'(frame_cnt), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_err", 64'(frame_err), 64'd0);
        in_valid = 1'b0;
        step;
        step;
        rst_n = 1'b1;
        step;
        chk("rerise_ready", 64'(in_ready), 64'd1);
        send(0, 59, 59, -1);
        check_frame("f4");
        do_ack;
        chk("f4_cnt", 64'(frame_cnt), 64'd1);

`ifdef LOADER_PARITY_EN
        send(0, 5, -1, 5);
        chk("par_err", 64'(frame_err), 64'd1);
        send(6, 59, 59, -1);
        chk("par_valid", 64'(vec_valid), 64'd0);
        chk("par_ready", 64'(in_ready), 64'd1);
        step;
        chk("par_back_valid", 64'(vec_valid), 64'd0);
        send(0, 59, 59, -1);
        check_frame("f5p");
        do_ack;
        chk("f5p_cnt", 64'(frame_cnt), 64'd2);
`else
        send(0, 59, 59, 5);
        check_frame("f5");
        do_ack;
        chk("f5_cnt", 64'(frame_cnt), 64'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
